// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver with parity, stop and timeout checking
module ps2_rx #(
  parameter int TIMEOUT_W = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic clk_prev;
  logic fall;
  logic tout;
  logic stop_ok;
  logic par_ok;
  logic [7:0] shift;
  logic [2:0] bcnt;
  logic [TIMEOUT_W-1:0] tcnt;
  assign fall = clk_prev & ~ps2_clk;
  assign tout = (state != IDLE) && (tcnt == '1) && !fall;
  assign stop_ok = ps2_data && par_ok;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state: a falling edge advances the frame, a stalled frame is abandoned
  always_comb begin
    state_n = state;
    if (tout)
      state_n = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_n = ps2_data ? IDLE : DATA;
        DATA:    state_n = (bcnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: state_n = IDLE;
      endcase
  end
  // outputs decoded from state
  always_comb
    busy = (state != IDLE);
  // edge detect, shifting, parity, timeout and the result strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev <= 1'b1;
      shift    <= '0;
      bcnt     <= '0;
      tcnt     <= '0;
      par_ok   <= 1'b0;
      data     <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      clk_prev <= ps2_clk;
      valid    <= fall && (state == STOP) && stop_ok;
      err      <= tout || (fall && (state == STOP) && !stop_ok);
      tcnt     <= (state == IDLE || fall) ? '0 : ((tcnt == '1) ? tcnt : tcnt + 1'b1);
      if (fall) begin
        if (state == IDLE)
          bcnt <= '0;
        if (state == DATA) begin
          shift <= {ps2_data, shift[7:1]};
          bcnt  <= bcnt + 3'd1;
        end
        if (state == PARITY)
          par_ok <= ^{shift, ps2_data};
        if (state == STOP && stop_ok)
          data <= shift;
      end
    end
  end
endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
Receives PS/2 device-to-host frames from the debounced PS/2 clock and data lines. Both lines come from two instances of the debouncer stage directly upstream. The block detects falling edges of the PS/2 clock and shifts in one 11-bit frame: start, 8 data bits LSB-first, odd parity, stop. It then presents the byte to the scan-code decoder downstream with a one-cycle valid strobe, or a one-cycle error strobe on a bad frame.

Parameters:
TIMEOUT_W, 14, width of the inter-edge timeout counter; a frame is aborted after 2^TIMEOUT_W - 1 system clocks without a PS/2 falling edge.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
ps2_clk  input  1  debounced PS/2 clock (idle high)
ps2_data  input  1  debounced PS/2 data (idle high)
data  output  8  last correctly received byte
valid  output  1  one-cycle pulse: data just updated
err  output  1  one-cycle pulse: frame rejected (parity, stop, or timeout)
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: rst is sampled on the rising clk edge (synchronous, active-high). On reset: state=IDLE, data=8'h00, valid=0, err=0, busy=0, bit counter=0, timeout counter=0, clk_prev=1.
- Edge detect: clk_prev is a registered copy of ps2_clk. fall = clk_prev & ~ps2_clk. ps2_data is sampled on the clk edge where fall=1.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - fall with ps2_data=0 -> DATA, bit counter=0.
  - fall with ps2_data=1 -> stay in IDLE (spurious start), no err.
- DATA:
  - Each fall shifts ps2_data into the MSB of the shift register, shifting right, so the LSB arrives first.
  - Bit counter increments; after the 8th bit -> PARITY.
- PARITY: on fall, capture the parity bit; parity_ok = ^{shift[7:0], bit} == 1 (odd). -> STOP.
- STOP:
  - On fall with ps2_data=1 and parity_ok: data <= shift and valid=1 on the next cycle. -> IDLE.
  - Any other case: err=1 on the next cycle, data unchanged. -> IDLE.
- Latency: valid/err rise on the clk edge following the clk edge where the stop-bit fall is detected. Each is high exactly one cycle; never both high at once.
- Timeout:
  - Counter cleared in IDLE and on every fall. Otherwise it increments while state != IDLE.
  - When it reaches all-ones with no fall that cycle: err pulse, state -> IDLE, partial frame discarded.
  - A fall in the same cycle wins: the counter clears and the frame continues.
  - The counter saturates and never wraps.
- data holds its value between frames; it changes only with valid.
- Reset mid-frame: immediate return to IDLE; the partial byte is discarded; no valid or err is emitted.
- busy is combinational from state (state != IDLE).

Test Plan:
1. Frame 0x1C: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1, ~2500-clk half-periods -> data=8'h1C, valid high exactly 1 cycle after the stop fall, err=0.
2. Same frame with parity=1 -> err one-cycle pulse, valid=0, data keeps its previous value (8'h1C from test 1 or 8'h00 after reset).
3. Frame 0xF0 (parity 1) with stop bit=0 -> err pulse, data unchanged. Then a correct 0xF0 frame -> data=8'hF0, valid pulse.
4. Single ps2_clk low pulse with ps2_data=1 in IDLE -> state stays IDLE, busy=0, no valid/err. A following 0x1C frame is received normally.
5. Start bit + 4 data bits, then ps2_clk held high for 2^TIMEOUT_W cycles (TIMEOUT_W=6 in the bench) -> err pulse, busy=0. A subsequent full frame 0x5A (parity 1) -> data=8'h5A, valid pulse.
6. rst=1 for one cycle after the 5th data bit of a frame -> busy=0, data=8'h00, no valid/err. The remainder of the interrupted frame is not accepted as a byte; the next clean frame is received correctly.
